mtr_drv: RTL
============

MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 SHALL have port: clk  input  1  system clock.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: lft_spd  input  12  signed left motor speed command, 2's complement.
REQ-004 SHALL have port: rght_spd  input  12  signed right motor speed command, 2's complement.
REQ-005 SHALL have port: OVR_I_lft  input  1  asynchronous over-current flag from the left bridge.
REQ-006 SHALL have port: OVR_I_rght  input  1  asynchronous over-current flag from the right bridge.
REQ-007 SHALL have port: clr_shtdwn  input  1  synchronous clear of a latched shutdown.
REQ-008 SHALL have port: PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght  output  1 each  H-bridge low-side and high-side gate drives.
REQ-009 SHALL have port: PWM_synch  output  1  one-clk pulse at each period end.
REQ-010 SHALL have port: ovr_i_shtdwn  output  1  latched over-current shutdown.
REQ-011 SHALL use these parameters, each shown as name, default, meaning: NONOVERLAP, 32, dead time in clks; BLANK, 128, over-current blanking window after dead time in clks; OVR_LIMIT, 4, consecutive faulted periods before shutdown.

Function
REQ-012 SHALL run one free-running 11-bit counter cnt shared by both channels: period 2048 clks, wraps 2047->0.
REQ-013 SHALL compute duty[10:0] = spd[11:1] with its MSB inverted (offset binary), so 0 -> 0x400, +2047 -> 0x7FF, -2048 -> 0x000.
REQ-014 SHALL latch each channel's duty only at cnt==2047 for use in the next period; mid-period input changes SHALL NOT affect the current period.
REQ-015 SHALL drive PWM2 high for NONOVERLAP <= cnt < duty, and low otherwise.
REQ-016 SHALL drive PWM1 high for cnt >= duty+NONOVERLAP, computed 12-bit wide so it never asserts when the sum is >= 2048.
REQ-017 SHALL register all PWM outputs: each output reflects the compare on the previous cnt, giving 1 clk of latency; both outputs of one bridge SHALL never be high together.
REQ-018 SHALL pulse PWM_synch high for exactly one clk when cnt==2047.
REQ-019 SHALL pass OVR_I_lft and OVR_I_rght each through a 2-flop synchronizer and OR them into ovr_evt.
REQ-020 SHALL set a per-period fault flag when ovr_evt is high while cnt >= NONOVERLAP+BLANK; events earlier in the period SHALL be ignored.
REQ-021 SHALL update at cnt==2047: a faulted period increments ovr_cnt (saturating at OVR_LIMIT) and a clean period clears ovr_cnt to 0; the fault flag SHALL clear for the next period.
REQ-022 SHALL set ovr_i_shtdwn on the clk after ovr_cnt reaches OVR_LIMIT, and keep it set until clr_shtdwn or reset.
REQ-023 SHALL clear ovr_i_shtdwn and ovr_cnt on clr_shtdwn; if a shutdown condition coincides with clr_shtdwn, clr_shtdwn SHALL win.
REQ-024 SHALL force all four PWM outputs low while ovr_i_shtdwn is high; cnt, duty latching and PWM_synch SHALL continue.

Reset
REQ-025 SHALL clear all of the following on reset: cnt, latched duties, synchronizers, fault flag, ovr_cnt, ovr_i_shtdwn, all PWM outputs and PWM_synch.
REQ-026 SHALL restart cleanly when reset is applied mid-period: after release, cnt starts at 0 and the first period uses duty 0x000 until the first latch at cnt==2047.

Structure
REQ-027 SHALL put PERIOD_BITS (11), NONOVERLAP, BLANK and OVR_LIMIT defaults in the shared package mtr_drv_pkg.
REQ-028 SHALL put the per-channel duty latch, compare and output registers in one sub-module, pwm11, instantiated twice and fed the shared cnt.

Verification
REQ-029 SHALL cover: lft_spd=0 -> PWM2_lft high for cnt 32..1023 (992 clks), PWM1_lft high for cnt 1056..2047 (992 clks), both low otherwise.
REQ-030 SHALL cover: rght_spd=+2047 -> PWM2_rght high for cnt 32..2046, PWM1_rght never high; rght_spd=-2048 -> PWM2_rght never high, PWM1_rght high for cnt 32..2047.
REQ-031 SHALL cover: lft_spd changed 0 -> +1024 at cnt=600 -> current period unchanged; next period duty=0x600, PWM2_lft high for cnt 32..1535.
REQ-032 SHALL cover: OVR_I_lft pulsed at cnt=500 in 4 consecutive periods -> ovr_i_shtdwn high after the 4th cnt==2047 and all PWM low; pulses at cnt=100 -> no count; a pattern of 3 faulted, 1 clean, 3 faulted periods -> no shutdown.
REQ-033 SHALL cover: clr_shtdwn pulse during shutdown -> ovr_i_shtdwn low and PWM resumes; clr_shtdwn coincident with the 4th fault update -> stays clear.
REQ-034 SHALL cover: rst_n asserted at cnt=1200 with outputs active -> all outputs low immediately, cnt=0 after release, PWM2 stays low for the whole first period.

Source files
------------

// File: rtl/mtr_drv_pkg.sv
// Shared constants and the speed-to-duty mapping for the dual H-bridge PWM driver.
package mtr_drv_pkg;

    localparam int PERIOD_BITS    = 11;
    localparam int NONOVERLAP_DFLT = 32;
    localparam int BLANK_DFLT      = 128;
    localparam int OVR_LIMIT_DFLT  = 4;

    localparam logic [PERIOD_BITS-1:0] CNT_MAX = '1;

    // Signed speed becomes offset-binary duty: drop the LSB, flip the sign bit.
    function automatic logic [PERIOD_BITS-1:0] spd_to_duty(input logic [PERIOD_BITS:0] spd);
        return {~spd[PERIOD_BITS], spd[PERIOD_BITS-1:1]};
    endfunction

endpackage

// File: rtl/pwm11.sv
// One H-bridge channel: duty latched at period end, dead-time compare, registered gate drives.
module pwm11
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = NONOVERLAP_DFLT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PERIOD_BITS-1:0] cnt,
    input  logic [PERIOD_BITS:0]   spd,
    input  logic                   kill,
    output logic                   pwm1,
    output logic                   pwm2
);

    localparam int                 CMP_W    = PERIOD_BITS + 1;
    localparam logic [CMP_W-1:0]   NONOVR_W = CMP_W'(NONOVERLAP);

    logic [PERIOD_BITS-1:0] duty;
    logic [CMP_W-1:0]       cnt_w;
    logic [CMP_W-1:0]       pwm1_thr;
    logic                   pwm1_cmp;
    logic                   pwm2_cmp;

    // Threshold kept one bit wider so duty+dead time past the period end never matches.
    assign cnt_w    = {1'b0, cnt};
    assign pwm1_thr = {1'b0, duty} + NONOVR_W;
    assign pwm1_cmp = (cnt_w >= pwm1_thr);
    assign pwm2_cmp = (cnt_w >= NONOVR_W) && (cnt < duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty <= '0;
        end else if (cnt == CNT_MAX) begin
            duty <= spd_to_duty(spd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm1 <= 1'b0;
            pwm2 <= 1'b0;
        end else begin
            pwm1 <= pwm1_cmp & ~kill;
            pwm2 <= pwm2_cmp & ~kill;
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Dual motor PWM driver: shared period counter, two bridge channels, over-current shutdown latch.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter int NONOVERLAP = NONOVERLAP_DFLT,
    parameter int BLANK      = BLANK_DFLT,
    parameter int OVR_LIMIT  = OVR_LIMIT_DFLT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PERIOD_BITS:0] lft_spd,
    input  logic [PERIOD_BITS:0] rght_spd,
    input  logic                 OVR_I_lft,
    input  logic                 OVR_I_rght,
    input  logic                 clr_shtdwn,
    output logic                 PWM1_lft,
    output logic                 PWM2_lft,
    output logic                 PWM1_rght,
    output logic                 PWM2_rght,
    output logic                 PWM_synch,
    output logic                 ovr_i_shtdwn
);

    localparam int                     OVR_W     = $clog2(OVR_LIMIT + 1);
    localparam logic [OVR_W-1:0]       OVR_MAX   = OVR_W'(OVR_LIMIT);
    localparam logic [PERIOD_BITS-1:0] BLANK_END = PERIOD_BITS'(NONOVERLAP + BLANK);

    logic [PERIOD_BITS-1:0] cnt;
    logic [1:0]             sync_l;
    logic [1:0]             sync_r;
    logic                   ovr_evt;
    logic                   fault;
    logic                   fault_now;
    logic                   period_end;
    logic                   shtdwn_nxt;
    logic [OVR_W-1:0]       ovr_cnt;

    assign period_end = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PERIOD_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_l <= '0;
            sync_r <= '0;
        end else begin
            sync_l <= {sync_l[0], OVR_I_lft};
            sync_r <= {sync_r[0], OVR_I_rght};
        end
    end

    assign ovr_evt = sync_l[1] | sync_r[1];

    // Events inside dead time plus blanking are switching transients, not real faults.
    assign fault_now = fault | (ovr_evt & (cnt >= BLANK_END));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else if (period_end) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt <= '0;
        end else if (clr_shtdwn) begin
            ovr_cnt <= '0;
        end else if (period_end) begin
            if (!fault_now) begin
                ovr_cnt <= '0;
            end else if (ovr_cnt != OVR_MAX) begin
                ovr_cnt <= ovr_cnt + OVR_W'(1);
            end
        end
    end

    // The next-state value gates the PWM registers so the drives drop on the same edge.
    assign shtdwn_nxt = ~clr_shtdwn & (ovr_i_shtdwn | (ovr_cnt == OVR_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_i_shtdwn <= 1'b0;
            PWM_synch    <= 1'b0;
        end else begin
            ovr_i_shtdwn <= shtdwn_nxt;
            PWM_synch    <= period_end;
        end
    end

    pwm11 #(.NONOVERLAP(NONOVERLAP)) u_pwm_lft (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .spd   (lft_spd),
        .kill  (shtdwn_nxt),
        .pwm1  (PWM1_lft),
        .pwm2  (PWM2_lft)
    );

    pwm11 #(.NONOVERLAP(NONOVERLAP)) u_pwm_rght (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt   (cnt),
        .spd   (rght_spd),
        .kill  (shtdwn_nxt),
        .pwm1  (PWM1_rght),
        .pwm2  (PWM2_rght)
    );

endmodule
